// File: rtl/lcd_sequencer.sv
// HD44780 write-only command sequencer: power-on init, then single-byte
// command/data writes with E setup/pulse/hold timing and execution waits.
module lcd_sequencer #(
    parameter int T_PWR = 750000,
    parameter int T_SU  = 2,
    parameter int T_EN  = 12,
    parameter int T_H   = 1,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       ready,
    output logic       init_done,
    output logic [7:0] lcd_data,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       blon
);

    localparam logic [2:0] PWR   = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] PULSE = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] EXEC  = 3'd4;
    localparam logic [2:0] IDLE  = 3'd5;

    // Counter reload values are N-1 so that each phase occupies exactly N cycles.
    localparam logic [CNT_W-1:0] PWR_LD = CNT_W'(T_PWR - 1);
    localparam logic [CNT_W-1:0] SU_LD  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] EN_LD  = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] H_LD   = CNT_W'(T_H - 1);
    localparam logic [CNT_W-1:0] CMD_LD = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] CLR_LD = CNT_W'(T_CLR - 1);

    logic [2:0]       stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [1:0]       idxReg, idxNext;
    logic [7:0]       dataReg, dataNext;
    logic             rsReg, rsNext;
    logic             enReg;
    logic             doneReg, doneNext;
    logic             phaseDone;
    logic             longCmd;
    logic             accept;

    function automatic logic [7:0] initRom(input logic [1:0] idx);
        case (idx)
            2'd0:    initRom = 8'h38;
            2'd1:    initRom = 8'h0C;
            2'd2:    initRom = 8'h01;
            default: initRom = 8'h06;
        endcase
    endfunction

    assign phaseDone = (cntReg == '0);
    assign accept    = (stateReg == IDLE) && doneReg && req;
    // Clear and return-home are the only slow instructions.
    assign longCmd   = !rsReg && ((dataReg == 8'h01) || (dataReg == 8'h02));

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        idxNext   = idxReg;
        dataNext  = dataReg;
        rsNext    = rsReg;
        doneNext  = doneReg;
        if (!phaseDone) begin
            cntNext = cntReg - CNT_W'(1);
        end
        case (stateReg)
            PWR: begin
                if (phaseDone) begin
                    stateNext = SETUP;
                    cntNext   = SU_LD;
                    idxNext   = 2'd0;
                    dataNext  = initRom(2'd0);
                    rsNext    = 1'b0;
                end
            end
            SETUP: begin
                if (phaseDone) begin
                    stateNext = PULSE;
                    cntNext   = EN_LD;
                end
            end
            PULSE: begin
                if (phaseDone) begin
                    stateNext = HOLD;
                    cntNext   = H_LD;
                end
            end
            HOLD: begin
                if (phaseDone) begin
                    stateNext = EXEC;
                    cntNext   = longCmd ? CLR_LD : CMD_LD;
                end
            end
            EXEC: begin
                if (phaseDone) begin
                    if (doneReg) begin
                        stateNext = IDLE;
                    end else if (idxReg == 2'd3) begin
                        stateNext = IDLE;
                        doneNext  = 1'b1;
                    end else begin
                        stateNext = SETUP;
                        cntNext   = SU_LD;
                        idxNext   = idxReg + 2'd1;
                        dataNext  = initRom(idxReg + 2'd1);
                        rsNext    = 1'b0;
                    end
                end
            end
            IDLE: begin
                if (accept) begin
                    stateNext = SETUP;
                    cntNext   = SU_LD;
                    dataNext  = req_data;
                    rsNext    = req_rs;
                end
            end
            default: begin
                stateNext = PWR;
                cntNext   = PWR_LD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg <= PWR;
            cntReg   <= PWR_LD;
            idxReg   <= 2'd0;
            dataReg  <= 8'h00;
            rsReg    <= 1'b0;
            enReg    <= 1'b0;
            doneReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            idxReg   <= idxNext;
            dataReg  <= dataNext;
            rsReg    <= rsNext;
            enReg    <= (stateNext == PULSE);
            doneReg  <= doneNext;
        end
    end

    // E comes straight from a flop so the LCD never sees a decode glitch.
    assign lcd_en    = enReg;
    assign lcd_data  = dataReg;
    assign lcd_rs    = rsReg;
    assign lcd_rw    = 1'b0;
    assign init_done = doneReg;
    assign ready     = (stateReg == IDLE) && doneReg;
    assign blon      = rst;

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

HD44780 command sequencer sitting between user logic and the LCD pins, replacing hand-driven `en`/`RS`/`RW` toggling. It runs the power-on initialisation sequence after reset and then accepts single-byte command/data writes through a ready/request handshake. For each write it generates the enable pulse with setup and hold intervals, then waits the controller execution time before accepting the next write. The interface is write-only (8-bit mode) and never polls the busy flag.

## Interface
- `T_PWR`, 750000, power-up wait in cycles (15 ms at 50 MHz)
- `T_SU`, 2, RS/data setup before `lcd_en` rises, in cycles
- `T_EN`, 12, `lcd_en` high width, in cycles
- `T_H`, 1, hold after `lcd_en` falls, in cycles
- `T_CMD`, 2000, execution wait for normal commands and data writes (40 µs)
- `T_CLR`, 82000, execution wait for clear (0x01) and home (0x02) commands (1.64 ms)
- `CNT_W`, 20, delay counter width; every `T_*` must be ≥1 and < 2^CNT_W
- `clk`  in  1  system clock
- `rst`  in  1  reset; asynchronous, active-low
- `req`  in  1  write request; accepted on an edge where `req && ready`
- `req_rs`  in  1  0 = command, 1 = data; sampled at acceptance
- `req_data`  in  8  byte to write; sampled at acceptance
- `ready`  out  1  idle and initialised; can accept a request
- `init_done`  out  1  init sequence complete; sticky until reset
- `lcd_data`  out  8  LCD DB7..DB0
- `lcd_en`  out  1  LCD E
- `lcd_rs`  out  1  LCD RS
- `lcd_rw`  out  1  LCD R/W; constant 0
- `blon`  out  1  backlight enable; 0 in reset, 1 otherwise

## Operation
- Reset values: `ready`, `init_done`, `lcd_en`, `lcd_rs`, `lcd_rw`, `blon` = 0; `lcd_data` = 0x00. The FSM is in PWR with the counter loaded to `T_PWR`.
- States: PWR, SETUP, PULSE, HOLD, EXEC, IDLE.
- PWR: wait `T_PWR` cycles, then start init write 0.
- Init ROM, all with RS = 0: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry mode). Each entry runs SETUP→PULSE→HOLD→EXEC. After EXEC of the last entry, go to IDLE and set `init_done` = 1.
- IDLE: `ready` = `init_done`. On acceptance, register `req_rs`/`req_data` onto `lcd_rs`/`lcd_data` at that edge and go to SETUP.
- SETUP: `T_SU` cycles, `lcd_en` = 0.
- PULSE: `T_EN` cycles, `lcd_en` = 1.
- HOLD: `T_H` cycles, `lcd_en` = 0.
- EXEC: wait `T_CLR` if RS = 0 and data ∈ {0x01, 0x02}; otherwise wait `T_CMD`. Then go to IDLE, or to the next init entry during init.
- `lcd_data`/`lcd_rs` stay stable from the load edge until the next load; input changes while busy have no effect.
- `req` while `ready` = 0 (including during init) is ignored, not queued.
- A request held high is accepted on the first edge `ready` is 1.
- Delay counter loads N−1 on phase entry and counts to 0, so each phase lasts exactly N cycles.

## Timing
- Acceptance at edge k: `ready` = 0 from k. `lcd_en` rises at k+`T_SU` and falls at k+`T_SU`+`T_EN`.
- `ready` returns at k+`T_SU`+`T_EN`+`T_H`+wait.
- Init: first data load at edge `T_PWR` after reset release. `init_done`/`ready` rise at `T_PWR` + 4·(`T_SU`+`T_EN`+`T_H`) + 3·`T_CMD` + `T_CLR`.
- Reset assertion at any point (including mid-pulse): all outputs go to reset values immediately, without waiting for `clk`. On release, init restarts from PWR.

## Test plan
Parameters for all scenarios: `T_PWR`=10, `T_SU`=2, `T_EN`=3, `T_H`=1, `T_CMD`=5, `T_CLR`=20.
- Init: release `rst` → four 3-cycle `lcd_en` pulses carrying 0x38, 0x0C, 0x01, 0x06 with `lcd_rs` = 0 and `lcd_rw` = 0. `init_done` and `ready` rise 69 cycles after release.
- Data write: `req_rs`=1, `req_data`=0x41 accepted at edge k → `lcd_en` high k+2..k+4 with `lcd_data` = 0x41 and `lcd_rs` = 1; `ready` back at k+11.
- Long commands: `req_rs`=0 with 0x01, then 0x02 → `ready` back at k+26 each time. 0x80 → back at k+11.
- Ignored requests: `req` high during init and mid-write → no extra pulses. With `req` held high, the next write is accepted on the edge `ready` returns. Changing `req_data` while busy leaves `lcd_data` unchanged.
- Reset mid-pulse: drop `rst` while `lcd_en` = 1 → `lcd_en`, `ready`, `init_done` = 0 immediately. On release, the full init sequence repeats with identical timing.
